ttt_turn_ctrl: RTL and testbench
================================

// Module: ttt_turn_ctrl
// PURPOSE
//  Game sequencer for the tic-tac-toe datapath. Consumes one-cycle key events from the keypad scanner.
//  Validates each move, writes the 18-bit board register and alternates turns.
//  Evaluates win/draw after every placement and latches the result for the 7-segment and dot-matrix drivers.
//  Sole owner and writer of the board, turn and result state.
// PARAMETERS
//  FIRST_O       0    1: O moves first after every clear; 0: X moves first
//  RESTART_CODE  10   key_code value that clears the board while in DONE ('*' key)
//  TURN_TIMEOUT  0    clk cycles allowed per move; 0 disables the timer; otherwise the idle player forfeits
// PORTS
//  clk         in   1   system clock (25 MHz board clock)
//  rst         in   1   synchronous, active-high reset
//  game_en     in   1   level; 1 = game mode, 0 = title/main screen (from IsMain dip)
//  key_valid   in   1   one-cycle pulse: key_code valid this cycle
//  key_code    in   4   1..9 = cell (row-major, cell1 top-left), 10 = '*', 11 = '#', 0 = '0'
//  board       out  18  cell n occupies bits [19-2n : 18-2n]; upper bit = O, lower bit = X
//  turn_o      out  1   1 = O to move, 0 = X to move
//  result      out  2   00 playing, 01 X wins, 10 O wins, 11 draw
//  move_cnt    out  4   stones placed since last clear (0..9)
//  illegal     out  1   one-cycle pulse: key rejected in WAIT_KEY
//  busy        out  1   1 in PLACE/CHECK; key events arriving then are dropped
// BEHAVIOUR
//  Reset: state=IDLE, board=0, turn_o=FIRST_O, result=00, move_cnt=0, illegal=0, busy=0, timer=0.
//  States: IDLE, WAIT_KEY, PLACE, CHECK, DONE.
//  IDLE:     board/result/move_cnt held at 0, turn_o=FIRST_O; game_en=1 -> WAIT_KEY next cycle.
//  Any state: game_en=0 -> IDLE next cycle with the same clearing as reset (takes priority over keys).
//  WAIT_KEY: key_valid with code 1..9 and target cell == 2'b00 -> latch cell, go PLACE.
//            key_valid with code 0, 10..15, or an occupied cell -> illegal=1 for that one cycle;
//            state, turn and board unchanged.
//            key_valid=0 -> stay.
//  PLACE (1 cycle):
//    set the current player's bit of the latched cell (O bit if turn_o=1, else X bit)
//    move_cnt+1; go CHECK.
//  CHECK (1 cycle), using the updated board:
//    the 8 lines (3 rows, 3 cols, 2 diagonals) are checked only for the player who just moved
//    line complete -> result=01/10, go DONE
//    else move_cnt==9 -> result=11, go DONE
//    else toggle turn_o, go WAIT_KEY
//    a win on the 9th stone reports the win, never draw.
//  Latency: key_valid in cycle t -> board visible at t+2, result/turn_o update at t+3;
//    next key accepted from t+3.
//  DONE: board, result and turn_o frozen. key_valid with key_code==RESTART_CODE clears board,
//    result and move_cnt and sets turn_o=FIRST_O; go WAIT_KEY. All other keys are ignored, no illegal pulse.
//  Timer: runs only in WAIT_KEY when TURN_TIMEOUT!=0; cleared on entering WAIT_KEY and on every key_valid.
//    When it reaches TURN_TIMEOUT-1: result = opponent wins (turn_o=0 -> 10, turn_o=1 -> 01); go DONE.
//    A key_valid in the same cycle as expiry wins over the expiry.
//  illegal is a registered output; it is 0 in every state except the cycle after a rejected WAIT_KEY key.
//  board never has both bits of a cell set; move_cnt saturates at 9.
// TESTING
//  1. Reset, game_en=1, keys 1,4,2,5,3 -> board=18'b01_01_01_10_10_00_00_00_00, result=01 after the last CHECK,
//     state DONE, turn_o=0.
//  2. Keys 5,5 -> second key gives illegal=1 for one cycle; board[9:8]=01 unchanged, turn_o stays 1.
//  3. Keys 1,2,3,5,4,6,8,7,9 -> all cells full with no line -> result=11, move_cnt=9.
//     Variant ending with a line on the 9th stone -> result=01 or 10, not 11.
//  4. In DONE, key 10 -> board=0, result=00, move_cnt=0, turn_o=FIRST_O; key 9 in DONE has no effect.
//  5. TURN_TIMEOUT=100: X moves, then no key for 100 cycles -> result=01 (O forfeits).
//     A key in the expiry cycle is accepted instead.
//  6. Mid-game, drop game_en for one cycle -> IDLE with board=0. Assert rst during CHECK -> all reset values next cycle.
//     key_valid pulses while busy=1 -> ignored.

Source files
------------

// File: rtl/ttt_turn_ctrl.sv
// Tic-tac-toe game sequencer: validates keypad moves, owns the board, turn and
// result registers, and judges win/draw after every stone.
module ttt_turn_ctrl #(
  parameter bit          FIRST_O      = 1'b0,
  parameter int unsigned RESTART_CODE = 10,
  parameter int unsigned TURN_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_en,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [17:0] board,
  output logic        turn_o,
  output logic [1:0]  result,
  output logic [3:0]  move_cnt,
  output logic        illegal,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_KEY,
    S_PLACE,
    S_CHECK,
    S_DONE
  } state_e;

  localparam int          TW          = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
  localparam int unsigned TLIM        = (TURN_TIMEOUT == 0) ? 0 : TURN_TIMEOUT - 1;
  localparam logic [TW-1:0] TMAX      = TW'(TLIM);
  localparam logic [3:0]  RESTART_KEY = 4'(RESTART_CODE);

  // Stones kept as two 9-bit masks, bit i = cell i+1 (row-major).
  state_e          state_q, state_d;
  logic [8:0]      x_q, x_d;
  logic [8:0]      o_q, o_d;
  logic [8:0]      cell_q, cell_d;
  logic            turn_q, turn_d;
  logic [1:0]      result_q, result_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            illegal_q, illegal_d;

  logic [15:0]     code_hot;
  logic [15:0]     occ_by_code;
  logic            cell_free;
  logic [8:0]      mover;

  function automatic logic has_line(input logic [8:0] m);
    has_line = (&m[2:0]) | (&m[5:3]) | (&m[8:6])
             | (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8])
             | (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
  endfunction

  assign code_hot    = 16'd1 << key_code;
  assign occ_by_code = {6'b0, x_q | o_q, 1'b0};
  assign cell_free   = (key_code >= 4'd1) && (key_code <= 4'd9) && !occ_by_code[key_code];
  assign mover       = turn_q ? o_q : x_q;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path through
    // the case below can leave one unassigned and infer a latch.
    state_d   = state_q;
    x_d       = x_q;
    o_d       = o_q;
    cell_d    = cell_q;
    turn_d    = turn_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    timer_d   = timer_q;
    illegal_d = 1'b0;

    if (!game_en) begin
      state_d  = S_IDLE;
      x_d      = '0;
      o_d      = '0;
      cell_d   = '0;
      turn_d   = FIRST_O;
      result_d = 2'b00;
      cnt_d    = '0;
      timer_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_WAIT_KEY;
          timer_d = '0;
        end

        S_WAIT_KEY: begin
          if (key_valid) begin
            timer_d = '0;
            if (cell_free) begin
              cell_d  = code_hot[9:1];
              state_d = S_PLACE;
            end else begin
              illegal_d = 1'b1;
            end
          end else if (TURN_TIMEOUT != 0) begin
            // The idle player forfeits: the opponent is reported as winner.
            if (timer_q == TMAX) begin
              result_d = turn_q ? 2'b01 : 2'b10;
              state_d  = S_DONE;
            end else begin
              timer_d = timer_q + 1'b1;
            end
          end
        end

        S_PLACE: begin
          if (turn_q) o_d = o_q | cell_q;
          else        x_d = x_q | cell_q;
          cnt_d   = (cnt_q == 4'd9) ? 4'd9 : cnt_q + 4'd1;
          state_d = S_CHECK;
        end

        S_CHECK: begin
          // Win is tested before the full-board draw so a 9th-stone line wins.
          if (has_line(mover)) begin
            result_d = turn_q ? 2'b10 : 2'b01;
            state_d  = S_DONE;
          end else if (cnt_q == 4'd9) begin
            result_d = 2'b11;
            state_d  = S_DONE;
          end else begin
            turn_d  = ~turn_q;
            timer_d = '0;
            state_d = S_WAIT_KEY;
          end
        end

        S_DONE: begin
          if (key_valid && (key_code == RESTART_KEY)) begin
            x_d      = '0;
            o_d      = '0;
            cell_d   = '0;
            turn_d   = FIRST_O;
            result_d = 2'b00;
            cnt_d    = '0;
            timer_d  = '0;
            state_d  = S_WAIT_KEY;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      o_q       <= '0;
      cell_q    <= '0;
      turn_q    <= FIRST_O;
      result_q  <= 2'b00;
      cnt_q     <= '0;
      timer_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      o_q       <= o_d;
      cell_q    <= cell_d;
      turn_q    <= turn_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      illegal_q <= illegal_d;
    end
  end

  // Cell n (1-based) drives board[19-2n] (O) and board[18-2n] (X).
  always_comb begin
    board = '0;
    for (int n = 0; n < 9; n++) begin
      board[17-2*n] = o_q[n];
      board[16-2*n] = x_q[n];
    end
  end

  assign turn_o   = turn_q;
  assign result   = result_q;
  assign move_cnt = cnt_q;
  assign illegal  = illegal_q;
  assign busy     = (state_q == S_PLACE) || (state_q == S_CHECK);

endmodule

// File: tb/tb_ttt_turn_ctrl.sv
// Bench for ttt_turn_ctrl: directed scenarios plus randomized play checked
// against a cell-array game model.
module tb_ttt_turn_ctrl;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        game_en;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [17:0] board;
  logic        turn_o;
  logic [1:0]  result;
  logic [3:0]  move_cnt;
  logic        illegal;
  logic        busy;

  always #5 clk = ~clk;

  ttt_turn_ctrl #(
    .FIRST_O      (1'b0),
    .RESTART_CODE (10),
    .TURN_TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .game_en   (game_en),
    .key_valid (key_valid),
    .key_code  (key_code),
    .board     (board),
    .turn_o    (turn_o),
    .result    (result),
    .move_cnt  (move_cnt),
    .illegal   (illegal),
    .busy      (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Game model: cells 0 empty / 1 X / 2 O; result 0 play, 1 X, 2 O, 3 draw.
  int  cells [9];
  bit  m_turn;
  int  m_result;
  int  m_moves;
  bit  m_illegal;
  bit  m_active;
  bit  m_over;
  int  m_busy_left;
  int  m_pend;
  int  m_idle;
  int  lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  function automatic bit m_wins(int p);
    for (int l = 0; l < 8; l++)
      if (cells[lines[l][0]] == p && cells[lines[l][1]] == p && cells[lines[l][2]] == p)
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [17:0] m_board();
    logic [17:0] b = '0;
    for (int n = 1; n <= 9; n++) begin
      if (cells[n-1] == 2) b[19-2*n] = 1'b1;
      if (cells[n-1] == 1) b[18-2*n] = 1'b1;
    end
    return b;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 9; i++) cells[i] = 0;
    m_turn = 1'b0; m_result = 0; m_moves = 0; m_over = 1'b0;
    m_busy_left = 0; m_idle = 0;
  endtask

  task automatic m_step(input bit r, input bit ge, input bit kv, input logic [3:0] kc);
    m_illegal = 1'b0;
    if (r || !ge) begin
      m_clear();
      m_active = 1'b0;
    end else if (!m_active) begin
      m_active = 1'b1;
      m_idle = 0;
    end else if (m_busy_left == 2) begin
      cells[m_pend] = m_turn ? 2 : 1;
      if (m_moves < 9) m_moves++;
      m_busy_left = 1;
    end else if (m_busy_left == 1) begin
      m_busy_left = 0;
      if (m_wins(m_turn ? 2 : 1)) begin
        m_result = m_turn ? 2 : 1; m_over = 1'b1;
      end else if (m_moves == 9) begin
        m_result = 3; m_over = 1'b1;
      end else begin
        m_turn = !m_turn; m_idle = 0;
      end
    end else if (m_over) begin
      if (kv && kc == 4'd10) m_clear();
    end else if (kv) begin
      m_idle = 0;
      if (kc >= 1 && kc <= 9 && cells[kc-1] == 0) begin
        m_pend = kc - 1; m_busy_left = 2;
      end else begin
        m_illegal = 1'b1;
      end
    end else if (m_idle == TO - 1) begin
      m_result = m_turn ? 1 : 2; m_over = 1'b1;
    end else begin
      m_idle++;
    end
  endtask

  // Drive one cycle of inputs, advance the model, return at the following negedge.
  task automatic tick(input bit r, input bit ge, input bit kv, input logic [3:0] kc);
    rst = r; game_en = ge; key_valid = kv; key_code = kc;
    m_step(r, ge, kv, kc);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 1'b0, 4'd0);
  endtask

  task automatic move(input int k);
    tick(1'b0, 1'b1, 1'b1, 4'(k));
    idle(2);
  endtask

  task automatic new_game();
    tick(1'b0, 1'b0, 1'b0, 4'd0);
    tick(1'b0, 1'b1, 1'b0, 4'd0);
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 1'b1, 4'd5);
    n_cmp++; if (board !== 18'd0) begin n_bad++; $display("FAIL reset_board: got %b want 0", board); end
    n_cmp++; if (turn_o !== 1'b0) begin n_bad++; $display("FAIL reset_turn: got %b want 0", turn_o); end
    n_cmp++; if (result !== 2'b00) begin n_bad++; $display("FAIL reset_result: got %b want 00", result); end
    n_cmp++; if (move_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", move_cnt); end
    n_cmp++; if (illegal !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got illegal=%b busy=%b want 0 0", illegal, busy); end
  endtask

  task automatic test_x_wins();
    tick(1'b0, 1'b1, 1'b0, 4'd0);
    tick(1'b0, 1'b1, 1'b1, 4'd1);
    n_cmp++; if (busy !== 1'b1 || board !== 18'd0) begin n_bad++; $display("FAIL lat_t1: got busy=%b board=%b want busy=1 board=0", busy, board); end
    idle(1);
    n_cmp++; if (board !== 18'b01_00_00_00_00_00_00_00_00 || turn_o !== 1'b0) begin n_bad++; $display("FAIL lat_t2: got board=%b turn=%b want cell1 X, turn 0", board, turn_o); end
    idle(1);
    n_cmp++; if (busy !== 1'b0 || turn_o !== 1'b1) begin n_bad++; $display("FAIL lat_t3: got busy=%b turn=%b want 0 1", busy, turn_o); end
    move(4); move(2); move(5); move(3);
    n_cmp++; if (board !== 18'b01_01_01_10_10_00_00_00_00) begin n_bad++; $display("FAIL xwin_board: got %b want 010101101000000000", board); end
    n_cmp++; if (result !== 2'b01 || turn_o !== 1'b0) begin n_bad++; $display("FAIL xwin_result: got result=%b turn=%b want 01 0", result, turn_o); end
    n_cmp++; if (move_cnt !== 4'd5) begin n_bad++; $display("FAIL xwin_cnt: got %0d want 5", move_cnt); end
  endtask

  task automatic test_illegal();
    tick(1'b0, 1'b1, 1'b1, 4'd10);
    move(5);
    tick(1'b0, 1'b1, 1'b1, 4'd5);
    n_cmp++; if (illegal !== 1'b1) begin n_bad++; $display("FAIL occupied_illegal: got %b want 1", illegal); end
    n_cmp++; if (board[9:8] !== 2'b01 || turn_o !== 1'b1) begin n_bad++; $display("FAIL occupied_state: got cell5=%b turn=%b want 01 1", board[9:8], turn_o); end
    idle(1);
    n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL illegal_pulse: got %b want 0", illegal); end
    tick(1'b0, 1'b1, 1'b1, 4'd0);
    n_cmp++; if (illegal !== 1'b1) begin n_bad++; $display("FAIL key0_illegal: got %b want 1", illegal); end
    tick(1'b0, 1'b1, 1'b1, 4'd12);
    n_cmp++; if (illegal !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL key12_illegal: got illegal=%b busy=%b want 1 0", illegal, busy); end
  endtask

  task automatic test_draw();
    int draw_keys [9] = '{1, 2, 3, 5, 4, 6, 8, 7, 9};
    int win_keys  [9] = '{1, 2, 3, 5, 4, 6, 8, 9, 7};
    new_game();
    foreach (draw_keys[i]) move(draw_keys[i]);
    n_cmp++; if (result !== 2'b11 || move_cnt !== 4'd9) begin n_bad++; $display("FAIL draw: got result=%b cnt=%0d want 11 9", result, move_cnt); end
    n_cmp++; if (board !== 18'b01_10_01_01_10_10_10_01_01) begin n_bad++; $display("FAIL draw_board: got %b want 011001011010100101", board); end
    new_game();
    foreach (win_keys[i]) move(win_keys[i]);
    n_cmp++; if (result !== 2'b01 || move_cnt !== 4'd9) begin n_bad++; $display("FAIL win9: got result=%b cnt=%0d want 01 9", result, move_cnt); end
  endtask

  task automatic test_restart();
    tick(1'b0, 1'b1, 1'b1, 4'd9);
    n_cmp++; if (board !== 18'b01_10_01_01_10_10_01_01_10 || result !== 2'b01 || illegal !== 1'b0) begin n_bad++; $display("FAIL done_key9: got board=%b result=%b illegal=%b want frozen", board, result, illegal); end
    tick(1'b0, 1'b1, 1'b1, 4'd11);
    n_cmp++; if (illegal !== 1'b0 || result !== 2'b01) begin n_bad++; $display("FAIL done_key11: got illegal=%b result=%b want 0 01", illegal, result); end
    tick(1'b0, 1'b1, 1'b1, 4'd10);
    n_cmp++; if (board !== 18'd0 || result !== 2'b00 || move_cnt !== 4'd0 || turn_o !== 1'b0) begin n_bad++; $display("FAIL restart: got board=%b result=%b cnt=%0d turn=%b want all 0", board, result, move_cnt, turn_o); end
    move(5);
    n_cmp++; if (board[9:8] !== 2'b01 || turn_o !== 1'b1) begin n_bad++; $display("FAIL after_restart: got cell5=%b turn=%b want 01 1", board[9:8], turn_o); end
  endtask

  task automatic test_timeout();
    new_game();
    move(5);
    idle(TO - 1);
    n_cmp++; if (result !== 2'b00) begin n_bad++; $display("FAIL timeout_early: got %b want 00", result); end
    idle(1);
    n_cmp++; if (result !== 2'b01 || turn_o !== 1'b1) begin n_bad++; $display("FAIL timeout_expire: got result=%b turn=%b want 01 1", result, turn_o); end
    tick(1'b0, 1'b1, 1'b1, 4'd1);
    n_cmp++; if (board[17:16] !== 2'b00 || illegal !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL timeout_frozen: got cell1=%b illegal=%b busy=%b want 00 0 0", board[17:16], illegal, busy); end
    new_game();
    move(5);
    idle(TO - 1);
    tick(1'b0, 1'b1, 1'b1, 4'd1);
    n_cmp++; if (busy !== 1'b1 || result !== 2'b00) begin n_bad++; $display("FAIL key_at_expiry: got busy=%b result=%b want 1 00", busy, result); end
    idle(2);
    n_cmp++; if (board[17:16] !== 2'b10 || result !== 2'b00 || turn_o !== 1'b0) begin n_bad++; $display("FAIL key_at_expiry_place: got cell1=%b result=%b turn=%b want 10 00 0", board[17:16], result, turn_o); end
  endtask

  task automatic test_game_en_drop();
    new_game();
    move(5); move(1);
    tick(1'b0, 1'b0, 1'b1, 4'd2);
    n_cmp++; if (board !== 18'd0 || turn_o !== 1'b0 || move_cnt !== 4'd0 || busy !== 1'b0) begin n_bad++; $display("FAIL en_drop: got board=%b turn=%b cnt=%0d busy=%b want all 0", board, turn_o, move_cnt, busy); end
    tick(1'b0, 1'b1, 1'b0, 4'd0);
    tick(1'b0, 1'b1, 1'b1, 4'd5);
    tick(1'b0, 1'b1, 1'b1, 4'd1);
    tick(1'b0, 1'b1, 1'b1, 4'd2);
    n_cmp++; if (board !== 18'b00_00_00_00_01_00_00_00_00 || turn_o !== 1'b1 || busy !== 1'b0 || illegal !== 1'b0) begin n_bad++; $display("FAIL busy_drop: got board=%b turn=%b busy=%b illegal=%b want cell5 X only, 1 0 0", board, turn_o, busy, illegal); end
    tick(1'b0, 1'b1, 1'b1, 4'd3);
    idle(1);
    tick(1'b1, 1'b1, 1'b0, 4'd0);
    n_cmp++; if (board !== 18'd0 || turn_o !== 1'b0 || result !== 2'b00 || move_cnt !== 4'd0 || busy !== 1'b0 || illegal !== 1'b0) begin n_bad++; $display("FAIL rst_in_check: got board=%b turn=%b result=%b cnt=%0d busy=%b illegal=%b want reset values", board, turn_o, result, move_cnt, busy, illegal); end
  endtask

  task automatic test_random();
    for (int blk = 0; blk < 8; blk++) begin
      int kv_den = (blk % 3 == 2) ? 150 : 3;
      for (int c = 0; c < 400; c++) begin
        bit r  = ($urandom_range(0, 599) == 0);
        bit ge = ($urandom_range(0, 249) != 0);
        bit kv = ($urandom_range(0, kv_den - 1) == 0);
        logic [3:0] kc = ($urandom_range(0, 3) == 0) ? 4'd10 : 4'($urandom_range(0, 15));
        tick(r, ge, kv, kc);
        n_cmp++; if (board !== m_board()) begin n_bad++; $display("FAIL rnd_board @%0t: got %b want %b", $time, board, m_board()); end
        n_cmp++; if (turn_o !== m_turn) begin n_bad++; $display("FAIL rnd_turn @%0t: got %b want %b", $time, turn_o, m_turn); end
        n_cmp++; if (result !== 2'(m_result)) begin n_bad++; $display("FAIL rnd_result @%0t: got %b want %0d", $time, result, m_result); end
        n_cmp++; if (move_cnt !== 4'(m_moves)) begin n_bad++; $display("FAIL rnd_cnt @%0t: got %0d want %0d", $time, move_cnt, m_moves); end
        n_cmp++; if (illegal !== m_illegal) begin n_bad++; $display("FAIL rnd_illegal @%0t: got %b want %b", $time, illegal, m_illegal); end
        n_cmp++; if (busy !== (m_busy_left != 0)) begin n_bad++; $display("FAIL rnd_busy @%0t: got %b want %b", $time, busy, m_busy_left != 0); end
      end
    end
  endtask

  initial begin
    m_clear();
    m_active = 1'b0;
    test_reset();
    test_x_wins();
    test_illegal();
    test_draw();
    test_restart();
    test_timeout();
    test_game_en_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
